// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO result registers for the E stage.
// The result is computed at accept and held back until the busy countdown expires.
module md_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             Occupied
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    localparam logic [WIDTH-1:0] MinInt = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic signed [2*WIDTH-1:0] a_sx, b_sx;
    logic signed [WIDTH-1:0]   quot_s, rem_s;
    logic [WIDTH-1:0]          quot_u, rem_u;
    logic [2*WIDTH-1:0]        mul_res, mulu_res, div_res, divu_res;

    // Results are packed as {hi, lo}.
    always_comb begin
        a_sx     = {{WIDTH{A[WIDTH-1]}}, A};
        b_sx     = {{WIDTH{B[WIDTH-1]}}, B};
        mul_res  = a_sx * b_sx;
        mulu_res = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        quot_s   = $signed(A) / $signed(B);
        rem_s    = $signed(A) % $signed(B);
        quot_u   = A / B;
        rem_u    = A % B;

        // Divide-by-zero and MIN/-1 are resolved explicitly, never left to the operator.
        if (B == '0) begin
            div_res = {A, {WIDTH{1'b1}}};
        end else if (A == MinInt && B == {WIDTH{1'b1}}) begin
            div_res = {{WIDTH{1'b0}}, MinInt};
        end else begin
            div_res = {rem_s, quot_s};
        end

        if (B == '0) begin
            divu_res = {A, {WIDTH{1'b1}}};
        end else begin
            divu_res = {rem_u, quot_u};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            StIdle: begin
                if (Start) begin
                    case (Op)
                        OpMult: begin
                            res_d   = mul_res;
                            cnt_d   = CntW'(MULT_CYCLES);
                            state_d = StBusy;
                        end
                        OpMultu: begin
                            res_d   = mulu_res;
                            cnt_d   = CntW'(MULT_CYCLES);
                            state_d = StBusy;
                        end
                        OpDiv: begin
                            res_d   = div_res;
                            cnt_d   = CntW'(DIV_CYCLES);
                            state_d = StBusy;
                        end
                        OpDivu: begin
                            res_d   = divu_res;
                            cnt_d   = CntW'(DIV_CYCLES);
                            state_d = StBusy;
                        end
                        OpMthi:  hi_d = A;
                        OpMtlo:  lo_d = A;
                        default: ;
                    endcase
                end
            end
            StBusy: begin
                // Any Start while busy is dropped on the floor.
                if (cnt_q == CntW'(1)) begin
                    hi_d    = res_q[2*WIDTH-1:WIDTH];
                    lo_d    = res_q[WIDTH-1:0];
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign HI       = hi_q;
    assign LO       = lo_q;
    assign Busy     = (state_q == StBusy);
    assign Occupied = Busy | (Start & (Op >= OpMult) & (Op <= OpDivu));

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: a 32-bit/5/10 instance and a 16-bit/1/1 instance, directed plus random ops
// checked against an arithmetic reference model.
module tb_md_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst32, st32, busy32, occ32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        rst16, st16, busy16, occ16;
    logic [2:0]  op16;
    logic [15:0] a16, b16, hi16, lo16;

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut32 (
        .clk(clk), .reset(rst32), .Start(st32), .Op(op32), .A(a32), .B(b32),
        .HI(hi32), .LO(lo32), .Busy(busy32), .Occupied(occ32)
    );

    md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut16 (
        .clk(clk), .reset(rst16), .Start(st16), .Op(op16), .A(a16), .B(b16),
        .HI(hi16), .LO(lo16), .Busy(busy16), .Occupied(occ16)
    );

    int tests  = 0;
    int failed = 0;

    int          wid[2]  = '{32, 16};
    int          mcyc[2] = '{5, 1};
    int          dcyc[2] = '{10, 1};
    logic [31:0] mhi[2];
    logic [31:0] mlo[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h, required %h", tag, obs, exp);
        end
    endtask

    // Reference model: {hi, lo} from plain integer arithmetic on w-bit operands.
    function automatic logic [63:0] model(input int w, input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, ua, ub, pu, hi, lo;
        longint      sa, sb, p, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'b0, a} & mask;
        ub   = {32'b0, b} & mask;
        sa   = longint'(ua);
        sb   = longint'(ub);
        if (ua[w-1]) sa = sa - (longint'(1) << w);
        if (ub[w-1]) sb = sb - (longint'(1) << w);
        hi = 64'd0;
        lo = 64'd0;
        case (op)
            3'd1: begin
                p  = sa * sb;
                pu = p;
                hi = (pu >> w) & mask;
                lo = pu & mask;
            end
            3'd2: begin
                pu = ua * ub;
                hi = (pu >> w) & mask;
                lo = pu & mask;
            end
            3'd3: begin
                if (ub == 64'd0) begin
                    hi = ua;
                    lo = mask;
                end else if (ua == (64'd1 << (w - 1)) && ub == mask) begin
                    hi = 64'd0;
                    lo = ua;
                end else begin
                    q  = sa / sb;
                    r  = sa - q * sb;
                    hi = r & mask;
                    lo = q & mask;
                end
            end
            3'd4: begin
                if (ub == 64'd0) begin
                    hi = ua;
                    lo = mask;
                end else begin
                    hi = ua % ub;
                    lo = ua / ub;
                end
            end
            default: ;
        endcase
        return {hi[31:0], lo[31:0]};
    endfunction

    task automatic drive(input int sel, input logic s, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b);
        if (sel == 0) begin
            st32 = s; op32 = o; a32 = a; b32 = b;
        end else begin
            st16 = s; op16 = o; a16 = a[15:0]; b16 = b[15:0];
        end
    endtask

    task automatic set_rst(input int sel, input logic v);
        if (sel == 0) rst32 = v;
        else          rst16 = v;
    endtask

    task automatic sample(input int sel, output logic bz, output logic oc,
                          output logic [31:0] h, output logic [31:0] l);
        if (sel == 0) begin
            bz = busy32; oc = occ32; h = hi32; l = lo32;
        end else begin
            bz = busy16; oc = occ16; h = {16'b0, hi16}; l = {16'b0, lo16};
        end
    endtask

    task automatic do_reset(input int sel, input string tag);
        logic bz, oc;
        logic [31:0] h, l;
        set_rst(sel, 1'b1);
        drive(sel, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        set_rst(sel, 1'b0);
        mhi[sel] = 32'd0;
        mlo[sel] = 32'd0;
        sample(sel, bz, oc, h, l);
        check({tag, ".busy"}, {31'b0, bz}, 32'd0);
        check({tag, ".occ"}, {31'b0, oc}, 32'd0);
        check({tag, ".hi"}, h, 32'd0);
        check({tag, ".lo"}, l, 32'd0);
    endtask

    // Starts a timed op at a negedge; optionally injects a Start while busy, or a reset.
    task automatic run_op(input int sel, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int intr_at, input int abort_at, input string tag);
        logic bz, oc;
        logic [31:0] h, l;
        int n;
        n = (o <= 3'd2) ? mcyc[sel] : dcyc[sel];
        drive(sel, 1'b1, o, a, b);
        #1;
        sample(sel, bz, oc, h, l);
        check({tag, ".occ_accept"}, {31'b0, oc}, 32'd1);
        check({tag, ".busy_accept"}, {31'b0, bz}, 32'd0);
        @(negedge clk);
        drive(sel, 1'b0, o, $urandom, $urandom);
        for (int k = 1; k <= n; k++) begin
            sample(sel, bz, oc, h, l);
            check($sformatf("%s.busy%0d", tag, k), {31'b0, bz}, 32'd1);
            check($sformatf("%s.hold_hi%0d", tag, k), h, mhi[sel]);
            check($sformatf("%s.hold_lo%0d", tag, k), l, mlo[sel]);
            if (k == abort_at) begin
                set_rst(sel, 1'b1);
                @(negedge clk);
                set_rst(sel, 1'b0);
                mhi[sel] = 32'd0;
                mlo[sel] = 32'd0;
                sample(sel, bz, oc, h, l);
                check({tag, ".abort_busy"}, {31'b0, bz}, 32'd0);
                check({tag, ".abort_hi"}, h, 32'd0);
                check({tag, ".abort_lo"}, l, 32'd0);
                for (int j = 0; j <= n; j++) begin
                    @(negedge clk);
                    sample(sel, bz, oc, h, l);
                    check($sformatf("%s.late_hi%0d", tag, j), h, 32'd0);
                    check($sformatf("%s.late_lo%0d", tag, j), l, 32'd0);
                    check($sformatf("%s.late_busy%0d", tag, j), {31'b0, bz}, 32'd0);
                end
                return;
            end
            if (k == intr_at) begin
                drive(sel, 1'b1, 3'd1, 32'd9, 32'd9);
                #1;
                sample(sel, bz, oc, h, l);
                check({tag, ".occ_busy"}, {31'b0, oc}, 32'd1);
            end
            @(negedge clk);
            if (k == intr_at) drive(sel, 1'b0, 3'd0, 32'd0, 32'd0);
        end
        sample(sel, bz, oc, h, l);
        check({tag, ".busy_done"}, {31'b0, bz}, 32'd0);
        check({tag, ".hi"}, h, ehi);
        check({tag, ".lo"}, l, elo);
        mhi[sel] = ehi;
        mlo[sel] = elo;
    endtask

    task automatic run_model_op(input int sel, input logic [2:0] o, input logic [31:0] a,
                                input logic [31:0] b, input string tag);
        logic [63:0] r;
        r = model(wid[sel], o, a, b);
        run_op(sel, o, a, b, r[63:32], r[31:0], 0, 0, tag);
    endtask

    task automatic run_mt(input int sel, input logic [2:0] o, input logic [31:0] a,
                          input string tag);
        logic bz, oc;
        logic [31:0] h, l, m;
        m = (sel == 0) ? a : {16'b0, a[15:0]};
        drive(sel, 1'b1, o, a, $urandom);
        #1;
        sample(sel, bz, oc, h, l);
        check({tag, ".occ"}, {31'b0, oc}, 32'd0);
        @(negedge clk);
        drive(sel, 1'b0, 3'd0, 32'd0, 32'd0);
        if (o == 3'd5) mhi[sel] = m;
        else           mlo[sel] = m;
        sample(sel, bz, oc, h, l);
        check({tag, ".busy"}, {31'b0, bz}, 32'd0);
        check({tag, ".hi"}, h, mhi[sel]);
        check({tag, ".lo"}, l, mlo[sel]);
    endtask

    task automatic run_nop(input int sel, input logic s, input logic [2:0] o,
                           input string tag);
        logic bz, oc;
        logic [31:0] h, l;
        drive(sel, s, o, $urandom, $urandom);
        #1;
        sample(sel, bz, oc, h, l);
        check({tag, ".occ"}, {31'b0, oc}, 32'd0);
        @(negedge clk);
        drive(sel, 1'b0, 3'd0, 32'd0, 32'd0);
        sample(sel, bz, oc, h, l);
        check({tag, ".busy"}, {31'b0, bz}, 32'd0);
        check({tag, ".hi"}, h, mhi[sel]);
        check({tag, ".lo"}, l, mlo[sel]);
    endtask

    task automatic random_ops(input int sel, input int count);
        logic [31:0] a, b;
        int r;
        for (int i = 0; i < count; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       a = (sel == 0) ? 32'h8000_0000 : 32'h0000_8000;
                default: ;
            endcase
            r = $urandom_range(0, 9);
            if (r >= 1 && r <= 4) begin
                run_model_op(sel, 3'(r), a, b, $sformatf("rnd%0d_%0d_op%0d", sel, i, r));
            end else if (r == 5 || r == 6) begin
                run_mt(sel, 3'(r), a, $sformatf("rnd%0d_%0d_mt%0d", sel, i, r));
            end else if (r == 0) begin
                run_nop(sel, 1'b0, 3'($urandom_range(0, 7)), $sformatf("rnd%0d_%0d_idle", sel, i));
            end else begin
                run_nop(sel, 1'b1, (r == 7) ? 3'd7 : 3'd0, $sformatf("rnd%0d_%0d_nop", sel, i));
            end
        end
    endtask

    initial begin
        rst32 = 1'b1; rst16 = 1'b1;
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
        do_reset(0, "reset32");
        do_reset(1, "reset16");

        // 32-bit, MULT_CYCLES=5, DIV_CYCLES=10
        run_op(0, 3'd1, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 0, "mult32");
        run_op(0, 3'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 0, 0, "multu32");
        run_op(0, 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, "div32");
        run_op(0, 3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 0, 0, "divu32");
        run_op(0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0, 0, "divovf32");
        run_op(0, 3'd4, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 0, 0, "divz32");
        run_mt(0, 3'd5, 32'hDEAD_BEEF, "mthi32");
        run_mt(0, 3'd6, 32'h5, "mtlo32");
        run_nop(0, 1'b1, 3'd0, "op0_32");
        run_nop(0, 1'b1, 3'd7, "op7_32");
        run_nop(0, 1'b0, 3'd1, "nostart32");
        run_op(0, 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 3, 0, "intr32");
        run_op(0, 3'd3, 32'd50, 32'd3, 32'd0, 32'd0, 0, 4, "abort32");
        random_ops(0, 25);

        // 16-bit, MULT_CYCLES=1, DIV_CYCLES=1
        run_op(1, 3'd1, 32'h8000, 32'h8000, 32'h4000, 32'h0000, 0, 0, "mult16");
        run_op(1, 3'd2, 32'hFFFF, 32'd2, 32'h0001, 32'hFFFE, 0, 0, "multu16");
        run_op(1, 3'd3, 32'hFFF9, 32'd2, 32'hFFFF, 32'hFFFD, 0, 0, "div16");
        run_op(1, 3'd3, 32'h8000, 32'hFFFF, 32'h0000, 32'h8000, 0, 0, "divovf16");
        run_op(1, 3'd4, 32'h1234, 32'd0, 32'h1234, 32'hFFFF, 0, 0, "divz16");
        run_mt(1, 3'd5, 32'hBEEF, "mthi16");
        run_mt(1, 3'd6, 32'h5, "mtlo16");
        run_op(1, 3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 1, 0, "intr16");
        run_op(1, 3'd4, 32'd50, 32'd3, 32'd0, 32'd0, 0, 1, "abort16");
        random_ops(1, 25);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit with HI/LO result registers for the pipelined CPU. It sits in the E stage beside the ALU.
- Operands arrive already forwarded (RS_E/RT_E forward-mux outputs). Results are read back through HI/LO for mfhi/mflo.
- Latency is configurable. Busy/Occupied feed the hazard unit, which stalls any D-stage md-class instruction while the unit is occupied.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (even, >=8)
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
Start  input  1  E-stage instruction is md-class this cycle (0 when E is bubble)
Op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
A  input  WIDTH  rs operand (forwarded)
B  input  WIDTH  rt operand (forwarded)
HI  output  WIDTH  HI register
LO  output  WIDTH  LO register
Busy  output  1  registered; operation in flight
Occupied  output  1  combinational: Busy | (Start & Op in 1..4)

Behaviour:
- Reset: HI=0, LO=0, Busy=0, internal counter=0, latched result cleared. Reset mid-operation aborts the operation. HI/LO are not written with the aborted result.
- Accept: on an edge with Start=1, Busy=0, Op in 1..4:
  - latch result {hi,lo}; counter := MULT_CYCLES (Op 1,2) or DIV_CYCLES (Op 3,4); Busy:=1 at that edge.
- Countdown: while Busy=1, counter decrements each edge. On the edge where counter==1, HI/LO := latched result, Busy:=0, counter:=0.
  - Busy is high for exactly N cycles after the accept edge.
  - New HI/LO are visible in the cycle Busy first reads 0.
- HI/LO hold their old values throughout Busy. mfhi/mflo is the hazard unit's responsibility to stall.
- Start with any Op while Busy=1: ignored entirely, with no restart and no HI/LO write. The hazard unit guarantees this does not occur in correct operation; the bench checks that it is ignored.
- mthi/mtlo (Op 5/6), Start=1, Busy=0: HI:=A or LO:=A at that edge. Busy stays 0. Zero latency.
- Arithmetic:
  - mult: signed 2*WIDTH product, HI=upper WIDTH bits, LO=lower.
  - multu: unsigned product.
  - div: LO=quotient truncated toward zero, HI=remainder with sign of dividend.
  - divu: unsigned.
- Boundary, divide by zero (B=0, div or divu): LO=all ones, HI=A. Busy still asserts for DIV_CYCLES.
- Boundary, signed overflow (div with A=MIN_INT, B=-1): LO=MIN_INT, HI=0.
- Op 0/7 with Start=1: no effect. Start=0: no effect regardless of Op.
- Occupied is high in the accept cycle (before Busy rises) so a following md instruction in D is stalled the same cycle.
- Operands are sampled only at the accept edge. A/B changes during Busy are don't-care.

Test Plan:
- Reset, then mult A=3, B=0xFFFFFFFE (-2), WIDTH=32, MULT_CYCLES=5 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Occupied high in the accept cycle.
- multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE. div A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after exactly 10 busy cycles. divu 7/2 -> LO=3, HI=1.
- div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. divu A=0x1234, B=0 -> LO=0xFFFFFFFF, HI=0x1234.
- mthi A=0xDEADBEEF, then mtlo A=0x5 on the next cycle -> HI=0xDEADBEEF, LO=5 one edge each; Busy never asserts.
- Start a div, then at busy cycle 3 drive Start=1 with Op=mult and A=B=9; check HI/LO are unchanged after div completion. Separately, assert reset at busy cycle 4 of another div -> HI=LO=0, Busy=0 next cycle, and no late write.
- Rerun the suite with WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=1 -> Busy is high exactly one cycle; mult 0x8000*0x8000 signed gives HI=0x4000, LO=0x0000.
